// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake and a
// multi-beat OR/AND accumulation mode that folds a packet into one result.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             acc_busy
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             acc_and_q, acc_and_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_zero_q, out_zero_d;

  logic             accept;
  logic             produce;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] beat_or;
  logic [WIDTH-1:0] beat_and;
  logic [WIDTH-1:0] fold;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_zero  = out_zero_q;
  assign acc_busy  = (state_q == ACC);

  assign beat_or  = in_a | in_b;
  assign beat_and = in_a & in_b;
  // Inside a packet the opcode latched on the first beat decides the fold.
  assign fold     = acc_and_q ? (acc_q & beat_and) : (acc_q | beat_or);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_and_d = acc_and_q;
    produce   = 1'b0;
    result    = '0;
    if (accept) begin
      if (state_q == IDLE) begin
        unique case (in_op)
          3'd0: begin produce = 1'b1; result = in_a & in_b;    end
          3'd1: begin produce = 1'b1; result = in_a | in_b;    end
          3'd2: begin produce = 1'b1; result = in_a ^ in_b;    end
          3'd3: begin produce = 1'b1; result = ~(in_a & in_b); end
          3'd4: begin produce = 1'b1; result = ~(in_a | in_b); end
          3'd5: begin produce = 1'b1; result = ~(in_a ^ in_b); end
          default: begin
            if (in_last) begin
              produce = 1'b1;
              result  = in_op[0] ? beat_and : beat_or;
            end else begin
              state_d   = ACC;
              acc_and_d = in_op[0];
              acc_d     = in_op[0] ? beat_and : beat_or;
            end
          end
        endcase
      end else begin
        if (in_last) begin
          produce = 1'b1;
          result  = fold;
          state_d = IDLE;
        end else begin
          acc_d = fold;
        end
      end
    end
  end

  // A new result may replace the one being handed off in the same cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_zero_d  = out_zero_q;
    if (produce) begin
      out_valid_d = 1'b1;
      out_y_d     = result;
      out_zero_d  = (result == '0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      acc_and_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_and_q   <= acc_and_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_zero_q  <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe (WIDTH=8): single ops, back-to-back
// issue, backpressure, accumulation packets and reset mid-packet.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
  logic       acc_busy;

  int checks;
  int errors;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .acc_busy(acc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic last);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_last  = last;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    out_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_y !== 8'h00) begin errors++; $display("[TB] FAIL reset_y got %h want 00", out_y); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero got %b want 0", out_zero); end
    checks++; if (acc_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", acc_busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_or();
    drive(1'b1, 3'd1, 8'hA0, 8'h05, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL or_valid got %b want 1", out_valid); end
    checks++; if (out_y !== 8'hA5) begin errors++; $display("[TB] FAIL or_y got %h want a5", out_y); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("[TB] FAIL or_zero got %b want 0", out_zero); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL or_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_y !== 8'h30) begin errors++; $display("[TB] FAIL b2b_and got v=%b y=%h want v=1 y=30", out_valid, out_y); end
    drive(1'b1, 3'd2, 8'hF0, 8'h3C, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_y !== 8'hCC) begin errors++; $display("[TB] FAIL b2b_xor got v=%b y=%h want v=1 y=cc", out_valid, out_y); end
    drive(1'b1, 3'd4, 8'hF0, 8'h3C, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_y !== 8'h03) begin errors++; $display("[TB] FAIL b2b_nor got v=%b y=%h want v=1 y=03", out_valid, out_y); end
    drive(1'b1, 3'd3, 8'hF0, 8'h3C, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_y !== 8'hCF) begin errors++; $display("[TB] FAIL b2b_nand got v=%b y=%h want v=1 y=cf", out_valid, out_y); end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 3'd5, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b1, 3'd1, 8'h11, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_y !== 8'hFF || out_zero !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold%0d got v=%b y=%h z=%b want v=1 y=ff z=0", i, out_valid, out_y, out_zero); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready%0d got %b want 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got %b want 1", in_ready); end
    checks++; if (out_y !== 8'hFF) begin errors++; $display("[TB] FAIL bp_still got %h want ff", out_y); end
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_y !== 8'h11) begin errors++; $display("[TB] FAIL bp_second got v=%b y=%h want v=1 y=11", out_valid, out_y); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_acc_or();
    drive(1'b1, 3'd6, 8'h01, 8'h00, 1'b0);
    tick();
    checks++; if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL accor_b1 got busy=%b v=%b want busy=1 v=0", acc_busy, out_valid); end
    drive(1'b1, 3'd3, 8'h10, 8'h00, 1'b0);
    tick();
    checks++; if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL accor_b2 got busy=%b v=%b want busy=1 v=0", acc_busy, out_valid); end
    drive(1'b0, 3'd0, 8'hFF, 8'hFF, 1'b1);
    tick();
    checks++; if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL accor_gap got busy=%b v=%b want busy=1 v=0", acc_busy, out_valid); end
    drive(1'b1, 3'd0, 8'h80, 8'h00, 1'b1);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_y !== 8'h91 || out_zero !== 1'b0) begin errors++; $display("[TB] FAIL accor_res got v=%b y=%h z=%b want v=1 y=91 z=0", out_valid, out_y, out_zero); end
    checks++; if (acc_busy !== 1'b0) begin errors++; $display("[TB] FAIL accor_done got %b want 0", acc_busy); end
    tick();
  endtask

  task automatic test_acc_and();
    drive(1'b1, 3'd7, 8'hFF, 8'h0F, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_y !== 8'h0F || acc_busy !== 1'b0) begin errors++; $display("[TB] FAIL accand1 got v=%b y=%h busy=%b want v=1 y=0f busy=0", out_valid, out_y, acc_busy); end
    drive(1'b1, 3'd7, 8'hFF, 8'hF0, 1'b0);
    tick();
    checks++; if (acc_busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL accand_b1 got busy=%b v=%b want busy=1 v=0", acc_busy, out_valid); end
    drive(1'b1, 3'd6, 8'h3C, 8'hFF, 1'b1);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_y !== 8'h30 || acc_busy !== 1'b0) begin errors++; $display("[TB] FAIL accand_res got v=%b y=%h busy=%b want v=1 y=30 busy=0", out_valid, out_y, acc_busy); end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    drive(1'b1, 3'd6, 8'hFF, 8'h00, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++; if (acc_busy !== 1'b1) begin errors++; $display("[TB] FAIL rmid_busy got %b want 1", acc_busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (acc_busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_clear got busy=%b v=%b want 0 0", acc_busy, out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd1, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_y !== 8'h00 || out_zero !== 1'b1 || acc_busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_after got v=%b y=%h z=%b busy=%b want 1 00 1 0", out_valid, out_y, out_zero, acc_busy); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_or();
    test_back_to_back();
    test_backpressure();
    test_acc_or();
    test_acc_and();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
